// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES datapath definitions: state geometry, round counts for the three
// key sizes, state/key vector types and the byte-position helper that maps a
// (row, column) coordinate onto the column-major state layout.
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int AES_WORD_SIZE      = 8;
   localparam int AES_ROWS           = 4;
   localparam int AES_NB             = 4;
   localparam int AES_NUM_ROUNDS_128 = 10;
   localparam int AES_NUM_ROUNDS_192 = 12;
   localparam int AES_NUM_ROUNDS_256 = 14;
   localparam int AES_STATE_W        = AES_WORD_SIZE * AES_ROWS * AES_NB;

   typedef logic [AES_STATE_W-1:0] state_t;
   typedef logic [AES_STATE_W-1:0] key_t;

   // State bytes are stored column by column, so byte (r, c) lives at
   // index c*ROWS + r within the flat state vector.
   function automatic int byte_index(input int r, input int c);
      return c * AES_ROWS + r;
   endfunction

endpackage

// File: rtl/ark_key_buffer.sv
// ---------------------------------------------------------------------------
// ark_key_buffer
// Round-key register file with one write port and one combinational read
// port. Holds NUM_ROUNDS+1 keys.
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset (clears every entry)
//   wr_en     - write wr_data into entry wr_idx (ignored if wr_idx > NUM_ROUNDS)
//   wr_idx    - write index
//   wr_data   - key to store
//   rd_idx    - read index
//   rd_data   - key at rd_idx, or the key being written to rd_idx this cycle;
//               zero when rd_idx is out of range
//   rd_err    - rd_idx > NUM_ROUNDS
// ---------------------------------------------------------------------------
module ark_key_buffer
   import aes_pkg::*;
#(
   parameter int W          = AES_STATE_W,
   parameter int NUM_ROUNDS = AES_NUM_ROUNDS_128,
   parameter int RW         = $clog2(NUM_ROUNDS + 1)
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [RW-1:0] wr_idx,
   input  logic [W-1:0]  wr_data,
   input  logic [RW-1:0] rd_idx,
   output logic [W-1:0]  rd_data,
   output logic          rd_err
);

   localparam logic [RW-1:0] MAX_IDX = RW'(NUM_ROUNDS);

   logic [W-1:0] mem [0:NUM_ROUNDS];
   logic         wr_ok;

   assign wr_ok = wr_en && (wr_idx <= MAX_IDX);

   // Key storage: reset wipes every entry so that no stale key from a previous
   // session can leak into a fresh run; out-of-range writes are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i <= NUM_ROUNDS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_ok) begin
         mem[wr_idx] <= wr_data;
      end
   end

   // Read side: a same-cycle write to the index being read is forwarded so the
   // consumer sees the newest key; an out-of-range index yields an all-zero key
   // so the state passes through the XOR untouched.
   always_comb begin
      rd_err  = (rd_idx > MAX_IDX);
      rd_data = '0;
      if (!rd_err) begin
         if (wr_ok && (wr_idx == rd_idx)) begin
            rd_data = wr_data;
         end else begin
            rd_data = mem[rd_idx];
         end
      end
   end

endmodule

// File: rtl/add_round_key_pipe.sv
// ---------------------------------------------------------------------------
// add_round_key_pipe
// Two-stage pipelined AES AddRoundKey. Each accepted state is XORed with the
// round key selected by its round index from an internal key buffer.
// Latency 2, throughput 1 per cycle, valid/ready on both sides.
//
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   key_wr_en    - write key_wr_data into key buffer entry key_wr_idx
//   key_wr_idx   - key buffer index
//   key_wr_data  - round key
//   in_valid     - input state valid
//   in_ready     - stage can accept (combinational from out_ready)
//   in_state     - state, byte i = c*ROWS+r at [i*WORD_SIZE +: WORD_SIZE]
//   in_round     - round index selecting the key
//   out_valid    - result valid
//   out_ready    - downstream accepts
//   out_state    - in_state XOR round key
//   out_round    - round index, passed through
//   out_err      - the round index of this result was above NUM_ROUNDS
//   xfer_cnt     - 32-bit count of output transfers (only with ARK_PERF_CNT_EN)
//
// Build option: define ARK_PERF_CNT_EN to add the xfer_cnt output.
// ---------------------------------------------------------------------------
module add_round_key_pipe
   import aes_pkg::*;
#(
   parameter int WORD_SIZE     = AES_WORD_SIZE,
   parameter int ROWS          = AES_ROWS,
   parameter int NB            = AES_NB,
   parameter int NUM_ROUNDS    = AES_NUM_ROUNDS_128,
   parameter int KEY_ROW_MAJOR = 0,
   parameter int RW            = $clog2(NUM_ROUNDS + 1)
)(
   input  logic                          clk,
   input  logic                          rst,
`ifdef ARK_PERF_CNT_EN
   output logic [31:0]                   xfer_cnt,
`endif
   input  logic                          key_wr_en,
   input  logic [RW-1:0]                 key_wr_idx,
   input  logic [WORD_SIZE*ROWS*NB-1:0]  key_wr_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [WORD_SIZE*ROWS*NB-1:0]  in_state,
   input  logic [RW-1:0]                 in_round,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WORD_SIZE*ROWS*NB-1:0]  out_state,
   output logic [RW-1:0]                 out_round,
   output logic                          out_err
);

   localparam int W = WORD_SIZE * ROWS * NB;

   logic          s1_valid;
   logic [W-1:0]  s1_state;
   logic [W-1:0]  s1_key;
   logic [RW-1:0] s1_round;
   logic          s1_err;

   logic [W-1:0]  key_rd;
   logic          key_err;
   logic [W-1:0]  key_x;
   logic          s2_adv;
   logic          s1_adv;
   logic          accept;

   ark_key_buffer #(
      .W          (W),
      .NUM_ROUNDS (NUM_ROUNDS),
      .RW         (RW)
   ) u_key_buf (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (key_wr_en),
      .wr_idx  (key_wr_idx),
      .wr_data (key_wr_data),
      .rd_idx  (in_round),
      .rd_data (key_rd),
      .rd_err  (key_err)
   );

   // No skid buffer: the input side can only move when S1 is empty or S1 is
   // about to move into S2, which in turn depends on the downstream ready.
   // in_ready is forced low while reset is asserted.
   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = !s1_valid || s2_adv;
   assign in_ready = !rst && s1_adv;
   assign accept   = in_valid && in_ready;

   // Key byte reordering: with row-major keys, state byte (r, c) must pick up
   // key byte r*NB+c instead of the matching column-major position.
   always_comb begin
      key_x = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < NB; c++) begin
            if (KEY_ROW_MAJOR != 0) begin
               key_x[(c*ROWS + r)*WORD_SIZE +: WORD_SIZE] = s1_key[(r*NB + c)*WORD_SIZE +: WORD_SIZE];
            end else begin
               key_x[(c*ROWS + r)*WORD_SIZE +: WORD_SIZE] = s1_key[(c*ROWS + r)*WORD_SIZE +: WORD_SIZE];
            end
         end
      end
   end

   // Stage 1: capture the state, its round index and the key as read in the
   // accept cycle, so later key writes cannot disturb this transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_state <= '0;
         s1_key   <= '0;
         s1_round <= '0;
         s1_err   <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= accept;
         if (accept) begin
            s1_state <= in_state;
            s1_key   <= key_rd;
            s1_round <= in_round;
            s1_err   <= key_err;
         end
      end
   end

   // Stage 2 / output registers: hold the XOR result; everything stays frozen
   // while the downstream stalls a valid result.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_state <= '0;
         out_round <= '0;
         out_err   <= 1'b0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_state <= s1_state ^ key_x;
            out_round <= s1_round;
            out_err   <= s1_err;
         end
      end
   end

`ifdef ARK_PERF_CNT_EN
   // Output transfer counter, free-running and wrapping at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         xfer_cnt <= '0;
      end else if (out_valid && out_ready) begin
         xfer_cnt <= xfer_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_add_round_key_pipe.sv
// ---------------------------------------------------------------------------
// tb_add_round_key_pipe
// Self-checking bench for add_round_key_pipe. Expected results are pushed to
// a scoreboard queue when a transfer is accepted and popped when it drains.
// A second instance with row-major keys covers the transposed key layout.
// ---------------------------------------------------------------------------
module tb_add_round_key_pipe;
   import aes_pkg::*;

   localparam int W  = 128;
   localparam int RW = 4;
   localparam int NR = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          key_wr_en;
   logic [RW-1:0] key_wr_idx;
   logic [W-1:0]  key_wr_data;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_state;
   logic [RW-1:0] in_round;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_state;
   logic [RW-1:0] out_round;
   logic          out_err;

   logic          t_key_wr_en;
   logic          t_in_valid;
   logic          t_in_ready;
   logic          t_out_valid;
   logic [W-1:0]  t_out_state;
   logic [RW-1:0] t_out_round;
   logic          t_out_err;

`ifdef ARK_PERF_CNT_EN
   logic [31:0]   xfer_cnt;
   logic [31:0]   t_xfer_cnt;
`endif

   int n_checks = 0;
   int n_errors = 0;
   int drained  = 0;
   int cyc      = 0;

   logic [W-1:0]  model_key [0:15];
   logic [W-1:0]  q_state [$];
   logic [RW-1:0] q_round [$];
   logic          q_err   [$];
   int            q_cyc   [$];

   add_round_key_pipe dut (
      .clk         (clk),
      .rst         (rst),
`ifdef ARK_PERF_CNT_EN
      .xfer_cnt    (xfer_cnt),
`endif
      .key_wr_en   (key_wr_en),
      .key_wr_idx  (key_wr_idx),
      .key_wr_data (key_wr_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_state    (in_state),
      .in_round    (in_round),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_state   (out_state),
      .out_round   (out_round),
      .out_err     (out_err)
   );

   add_round_key_pipe #(.KEY_ROW_MAJOR(1)) dut_t (
      .clk         (clk),
      .rst         (rst),
`ifdef ARK_PERF_CNT_EN
      .xfer_cnt    (t_xfer_cnt),
`endif
      .key_wr_en   (t_key_wr_en),
      .key_wr_idx  (key_wr_idx),
      .key_wr_data (key_wr_data),
      .in_valid    (t_in_valid),
      .in_ready    (t_in_ready),
      .in_state    (in_state),
      .in_round    (in_round),
      .out_valid   (t_out_valid),
      .out_ready   (out_ready),
      .out_state   (t_out_state),
      .out_round   (t_out_round),
      .out_err     (t_out_err)
   );

   // Free-running clock and a cycle counter used for latency measurement.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Put every input back to its quiet value.
   task automatic idle_inputs();
      key_wr_en   = 1'b0;
      t_key_wr_en = 1'b0;
      key_wr_idx  = '0;
      key_wr_data = '0;
      in_valid    = 1'b0;
      t_in_valid  = 1'b0;
      in_state    = '0;
      in_round    = '0;
      out_ready   = 1'b1;
   endtask

   // Forget every in-flight expectation and return the key model to zero.
   task automatic clear_model();
      q_state.delete();
      q_round.delete();
      q_err.delete();
      q_cyc.delete();
      for (int i = 0; i < 16; i++) model_key[i] = '0;
      drained = 0;
   endtask

   // Reference model for the main instance, evaluated once per cycle after the
   // inputs have settled: apply a pending key write (making a same-index read
   // see the new key), then push the expected result of an accepted transfer.
   task automatic note_cycle();
      logic [W-1:0] k;
      if (!rst && key_wr_en && int'(key_wr_idx) <= NR) model_key[key_wr_idx] = key_wr_data;
      if (in_valid && in_ready) begin
         k = (int'(in_round) <= NR) ? model_key[in_round] : '0;
         q_state.push_back(in_state ^ k);
         q_round.push_back(in_round);
         q_err.push_back(int'(in_round) > NR);
         q_cyc.push_back(cyc);
      end
   endtask

   // Wait (bounded) for the next drained result of the main instance and hand
   // back both what the DUT showed and what the scoreboard expected.
   task automatic wait_result(output logic [W-1:0] st, output logic [RW-1:0] rd, output logic er,
                              output logic [W-1:0] e_st, output logic [RW-1:0] e_rd, output logic e_er,
                              output int lat, output bit ok);
      ok = 1'b0;
      st = '0; rd = '0; er = 1'b0; e_st = '0; e_rd = '0; e_er = 1'b0; lat = 0;
      for (int i = 0; i < 20; i++) begin
         if (out_valid && out_ready && q_state.size() != 0) begin
            st   = out_state;
            rd   = out_round;
            er   = out_err;
            e_st = q_state.pop_front();
            e_rd = q_round.pop_front();
            e_er = q_err.pop_front();
            lat  = cyc - q_cyc.pop_front();
            drained++;
            ok = 1'b1;
            @(negedge clk); #1;
            break;
         end
         @(negedge clk); #1;
      end
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_errors++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
      end
      n_checks++;
      if (out_valid !== 1'b0 || out_state !== '0 || out_round !== '0 || out_err !== 1'b0) begin
         n_errors++;
         $display("[TB] FAIL reset_outputs: got valid=%b state=%h round=%0d err=%b expected all zero",
                  out_valid, out_state, out_round, out_err);
      end
      n_checks++;
      if (t_out_valid !== 1'b0 || t_in_ready !== 1'b0) begin
         n_errors++; $display("[TB] FAIL reset_transpose_inst: got valid=%b ready=%b expected 0 0", t_out_valid, t_in_ready);
      end
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++; $display("[TB] FAIL ready_after_reset: got %b expected 1", in_ready);
      end
   endtask

   task automatic test_fips_round0();
      logic [W-1:0] st, e_st;
      logic [RW-1:0] rd, e_rd;
      logic er, e_er;
      int lat;
      bit ok;
      @(negedge clk);
      key_wr_en = 1'b1; key_wr_idx = 4'd0; key_wr_data = 128'h000102030405060708090a0b0c0d0e0f;
      #1 note_cycle();
      @(negedge clk);
      key_wr_en = 1'b0;
      in_valid = 1'b1; in_state = 128'h00112233445566778899aabbccddeeff; in_round = 4'd0;
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_errors++; $display("[TB] FAIL fips_accept: in_ready got %b expected 1", in_ready);
      end
      note_cycle();
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      wait_result(st, rd, er, e_st, e_rd, e_er, lat, ok);
      n_checks++;
      if (!ok) begin
         n_errors++; $display("[TB] FAIL fips_timeout: no result within budget");
      end else begin
         if (st !== 128'h00102030405060708090a0b0c0d0e0f0 || st !== e_st) begin
            n_errors++; $display("[TB] FAIL fips_state: got %h expected %h", st, 128'h00102030405060708090a0b0c0d0e0f0);
         end
         n_checks++;
         if (er !== 1'b0 || rd !== 4'd0) begin
            n_errors++; $display("[TB] FAIL fips_err_round: got err=%b round=%0d expected err=0 round=0", er, rd);
         end
         n_checks++;
         if (lat !== 2) begin
            n_errors++; $display("[TB] FAIL fips_latency: got %0d cycles expected 2", lat);
         end
      end
   endtask

   task automatic test_back_to_back();
      int sent = 0;
      int recv = 0;
      int cycles = 0;
      int stall_checks = 0;
      for (int i = 0; i <= NR; i++) begin
         @(negedge clk);
         key_wr_en = 1'b1; key_wr_idx = RW'(i); key_wr_data = {16{8'(i)}};
         #1 note_cycle();
      end
      @(negedge clk);
      key_wr_en = 1'b0;
      while ((sent < NR + 1 || q_state.size() != 0) && cycles < 80) begin
         in_valid  = (sent < NR + 1);
         in_state  = '0;
         in_round  = RW'(sent);
         out_ready = !(cycles >= 5 && cycles <= 7);
         #1;
         if (out_valid) begin
            n_checks++;
            if (q_state.size() == 0) begin
               n_errors++; $display("[TB] FAIL b2b_spurious: got output round %0d expected none", out_round);
            end else if (out_state !== q_state[0] || out_round !== q_round[0] || out_err !== q_err[0]) begin
               n_errors++;
               $display("[TB] FAIL b2b_data: got state=%h round=%0d err=%b expected state=%h round=%0d err=%b",
                        out_state, out_round, out_err, q_state[0], q_round[0], q_err[0]);
            end
            if (!out_ready && q_state.size() >= 2) begin
               n_checks++;
               stall_checks++;
               if (in_ready !== 1'b0) begin
                  n_errors++; $display("[TB] FAIL b2b_stall_ready: got %b expected 0", in_ready);
               end
            end
            if (out_ready && q_state.size() != 0) begin
               void'(q_state.pop_front());
               void'(q_round.pop_front());
               void'(q_err.pop_front());
               void'(q_cyc.pop_front());
               recv++;
               drained++;
            end
         end
         if (in_valid && in_ready) sent++;
         note_cycle();
         cycles++;
         @(negedge clk);
      end
      idle_inputs();
      n_checks++;
      if (sent != NR + 1 || recv != NR + 1 || stall_checks == 0) begin
         n_errors++;
         $display("[TB] FAIL b2b_count: got sent=%0d recv=%0d stall_checks=%0d expected %0d %0d nonzero",
                  sent, recv, stall_checks, NR + 1, NR + 1);
      end
`ifdef ARK_PERF_CNT_EN
      #1;
      n_checks++;
      if (xfer_cnt !== 32'(drained)) begin
         n_errors++; $display("[TB] FAIL xfer_cnt: got %0d expected %0d", xfer_cnt, drained);
      end
`endif
   endtask

   task automatic test_same_cycle();
      logic [W-1:0] pat, st, e_st;
      logic [RW-1:0] rd, e_rd;
      logic er, e_er;
      int lat;
      bit ok;
      pat = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      key_wr_en = 1'b1; key_wr_idx = 4'd3; key_wr_data = '1;
      in_valid = 1'b1; in_round = 4'd3; in_state = pat;
      #1 note_cycle();
      @(negedge clk);
      idle_inputs();
      #1;
      wait_result(st, rd, er, e_st, e_rd, e_er, lat, ok);
      n_checks++;
      if (!ok) begin
         n_errors++; $display("[TB] FAIL bypass_timeout: no result within budget");
      end else if (st !== ~pat || st !== e_st || er !== 1'b0) begin
         n_errors++; $display("[TB] FAIL bypass_state: got %h err=%b expected %h err=0", st, er, ~pat);
      end
   endtask

   task automatic test_out_of_range();
      logic [W-1:0] pat, st, e_st;
      logic [RW-1:0] rd, e_rd;
      logic er, e_er;
      int lat;
      bit ok;
      pat = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      key_wr_en = 1'b1; key_wr_idx = 4'd12; key_wr_data = {16{8'hA5}};
      #1 note_cycle();
      @(negedge clk);
      key_wr_en = 1'b0;
      in_valid = 1'b1; in_round = 4'd12; in_state = pat;
      #1 note_cycle();
      @(negedge clk);
      in_round = 4'd1;
      #1 note_cycle();
      @(negedge clk);
      idle_inputs();
      #1;
      wait_result(st, rd, er, e_st, e_rd, e_er, lat, ok);
      n_checks++;
      if (!ok || st !== pat || st !== e_st || er !== 1'b1 || rd !== 4'd12) begin
         n_errors++; $display("[TB] FAIL oor_result: got ok=%b state=%h err=%b round=%0d expected state=%h err=1 round=12",
                              ok, st, er, rd, pat);
      end
      wait_result(st, rd, er, e_st, e_rd, e_er, lat, ok);
      n_checks++;
      if (!ok || st !== e_st || er !== 1'b0 || rd !== 4'd1) begin
         n_errors++; $display("[TB] FAIL oor_err_clear: got ok=%b state=%h err=%b round=%0d expected state=%h err=0 round=1",
                              ok, st, er, rd, e_st);
      end
   endtask

   task automatic test_transpose();
      logic [W-1:0] exp_t;
      logic [7:0] b1;
      bit got = 1'b0;
      for (int k = 0; k < 16; k++) key_wr_data[k*8 +: 8] = 8'(k);
      for (int r = 0; r < AES_ROWS; r++)
         for (int c = 0; c < AES_NB; c++)
            exp_t[byte_index(r, c)*8 +: 8] = 8'(r*AES_NB + c);
      @(negedge clk);
      t_key_wr_en = 1'b1; key_wr_idx = 4'd5;
      @(negedge clk);
      t_key_wr_en = 1'b0;
      t_in_valid = 1'b1; in_state = '0; in_round = 4'd5;
      #1;
      n_checks++;
      if (t_in_ready !== 1'b1) begin
         n_errors++; $display("[TB] FAIL transpose_accept: in_ready got %b expected 1", t_in_ready);
      end
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk); #1;
         if (t_out_valid) begin
            got = 1'b1;
            b1 = t_out_state[15:8];
            n_checks++;
            if (t_out_state !== exp_t || b1 !== 8'h04) begin
               n_errors++; $display("[TB] FAIL transpose_state: got %h expected %h", t_out_state, exp_t);
            end
            n_checks++;
            if (t_out_err !== 1'b0 || t_out_round !== 4'd5) begin
               n_errors++; $display("[TB] FAIL transpose_meta: got err=%b round=%0d expected 0 5", t_out_err, t_out_round);
            end
         end
      end
      if (!got) begin
         n_checks++; n_errors++; $display("[TB] FAIL transpose_timeout: no result within budget");
      end
   endtask

   task automatic test_reset_mid();
      logic [W-1:0] pat, st, e_st;
      logic [RW-1:0] rd, e_rd;
      logic er, e_er;
      int lat;
      bit ok;
      bit stray = 1'b0;
      pat = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; in_state = pat; in_round = 4'd2;
      #1 note_cycle();
      @(negedge clk);
      #1 note_cycle();
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      n_checks++;
      if (out_valid !== 1'b1 || q_state.size() != 2 || in_ready !== 1'b0) begin
         n_errors++; $display("[TB] FAIL rst_mid_full: got out_valid=%b inflight=%0d in_ready=%b expected 1 2 0",
                              out_valid, q_state.size(), in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      clear_model();
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_state !== '0 || out_err !== 1'b0) begin
         n_errors++; $display("[TB] FAIL rst_mid_outputs: got valid=%b state=%h err=%b expected 0 0 0", out_valid, out_state, out_err);
      end
`ifdef ARK_PERF_CNT_EN
      n_checks++;
      if (xfer_cnt !== 32'd0) begin
         n_errors++; $display("[TB] FAIL rst_mid_xfer_cnt: got %0d expected 0", xfer_cnt);
      end
`endif
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); #1;
         if (out_valid !== 1'b0) stray = 1'b1;
      end
      n_checks++;
      if (stray) begin
         n_errors++; $display("[TB] FAIL rst_mid_stray: got out_valid=1 after reset expected 0");
      end
      @(negedge clk);
      in_valid = 1'b1; in_state = pat; in_round = 4'd2;
      #1 note_cycle();
      @(negedge clk);
      idle_inputs();
      #1;
      wait_result(st, rd, er, e_st, e_rd, e_er, lat, ok);
      n_checks++;
      if (!ok || st !== pat || st !== e_st || er !== 1'b0) begin
         n_errors++; $display("[TB] FAIL rst_mid_key_cleared: got ok=%b state=%h err=%b expected state=%h err=0", ok, st, er, pat);
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      clear_model();
      repeat (2) @(posedge clk);
      test_reset();
      test_fips_round0();
      test_back_to_back();
      test_same_cycle();
      test_out_of_range();
      test_transpose();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/add_round_key_pipe.md
Name: add_round_key_pipe

Overview:
Parametrised, pipelined AddRoundKey stage for the AES datapath. It holds an internal round-key buffer of NUM_ROUNDS+1 entries, written through a load port. Each accepted state is XORed with the round key selected by its round index. It accepts one state per cycle over valid/ready handshakes, and can optionally transpose row-major keys into the column-major state layout.

Parameters:
WORD_SIZE, 8, bits per state byte
ROWS, 4, rows of the state matrix
NB, 4, columns of the state matrix; state width W = WORD_SIZE*ROWS*NB
NUM_ROUNDS, 10, last valid round index; key buffer depth = NUM_ROUNDS+1
KEY_ROW_MAJOR, 0, 1 = key words are stored row-major and are transposed on read
RW, $clog2(NUM_ROUNDS+1), width of round indices

Ports:
clk  in  1  clock
rst  in  1  reset
key_wr_en  in  1  write key_wr_data into the key buffer at key_wr_idx
key_wr_idx  in  RW  key buffer index
key_wr_data  in  W  round key
in_valid  in  1  input state valid
in_ready  out  1  stage can accept
in_state  in  W  state; byte i = c*ROWS+r, located at [i*WORD_SIZE +: WORD_SIZE]
in_round  in  RW  round index selecting the key
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
out_state  out  W  state XOR key
out_round  out  RW  round index, passed through
out_err  out  1  in_round was greater than NUM_ROUNDS

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - On reset: out_valid=0, out_state=0, out_round=0, out_err=0, all internal valids=0.
  - The key buffer is cleared to 0. On the reset cycle in_ready=0.
- Pipeline: two register stages, S1 and S2.
  - A transfer is accepted when in_valid && in_ready.
  - Cycle t+1: S1 holds the state, round index and key read.
  - Cycle t+2: S2/out registers hold the XOR result and out_valid=1. Latency 2; throughput 1 per cycle.
- Flow control:
  - S2 advances when !out_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advance condition (combinational from out_ready; no skid).
  - While out_valid && !out_ready, out_state, out_round and out_err are held stable.
- Key read:
  - The key is read at the accept cycle.
  - If key_wr_en is asserted to the same index in that cycle, the new key_wr_data is used (write-through bypass).
  - Writes to entries already captured in S1/S2 do not affect in-flight data.
- Transpose:
  - KEY_ROW_MAJOR=1: state byte c*ROWS+r is XORed with key byte r*NB+c.
  - KEY_ROW_MAJOR=0: state byte i is XORed with key byte i.
- Out-of-range round (in_round > NUM_ROUNDS):
  - The key is treated as 0, out_err=1 with that result, and the state passes unchanged.
  - out_err is cleared with the next accepted transfer.
- A key write with key_wr_idx > NUM_ROUNDS is ignored.
- Simultaneous accept and drain in the same cycle are allowed, with no bubble.
- Reset mid-operation drops all in-flight transfers; nothing is output after reset until a new accept.

Optional Feature:
ARK_PERF_CNT_EN
- Defined: adds output xfer_cnt (32 bits).
  - Increments on each out_valid && out_ready.
  - Wraps 0xFFFFFFFF -> 0.
  - Cleared by rst.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package aes_pkg:
  - AES_WORD_SIZE, AES_ROWS, AES_NB, AES_NUM_ROUNDS_128/192/256 constants.
  - state_t/key_t typedefs.
  - byte_index(r,c) function.
- One sub-module, ark_key_buffer: register file with 1 write and 1 read port, write-through bypass, and out-of-range detect.
- The pipeline and XOR stay in the top module.

Test Plan:
- FIPS-197 round 0, KEY_ROW_MAJOR=0:
  - Stimulus: load idx 0 = 000102030405060708090a0b0c0d0e0f; send state 00112233445566778899aabbccddeeff with round 0.
  - Required: out_state = 00102030405060708090a0b0c0d0e0f0 exactly 2 cycles after accept, out_err=0.
- Back-to-back and backpressure:
  - Stimulus: stream rounds 0..10, keys idx = {16{8'(idx)}}, state all 0x00; hold out_ready=0 for 3 cycles mid-stream.
  - Required: outputs in order, each byte equal to its round index; held data stable while stalled; no loss or duplication; in_ready=0 during the stall once S1 and S2 are full.
- Transpose, KEY_ROW_MAJOR=1:
  - Stimulus: key byte k = k; state zero.
  - Required: out byte c*4+r = r*4+c, e.g. out byte 1 = 0x04.
- Same-cycle write/read:
  - Stimulus: accept round 3 in the cycle that key_wr_idx=3 writes all-0xFF.
  - Required: out_state = ~in_state.
- Out-of-range:
  - Stimulus: in_round=12 with NUM_ROUNDS=10.
  - Required: out_state = in_state, out_err=1; key write to idx 12 has no effect.
- Reset mid-stream:
  - Stimulus: assert rst with S1 and S2 full.
  - Required: out_valid=0 on the next cycle, key buffer reads 0, xfer_cnt=0 when ARK_PERF_CNT_EN is defined.
